// File: rtl/sifh_peak_reader.sv
// sifh_peak_reader: scans every histogram bin through SRAM port b and reports the peak bin of each pixel
module sifh_peak_reader #(
  parameter int BIN_NUM   = 16,
  parameter int PIXEL_NUM = 4,
  parameter int NB        = 4,
  parameter int PIX_W     = 2,
  parameter int RAM_ADDR  = 6,
  parameter int CNT_W     = 10
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [CNT_W-1:0]    counts,
  output logic [RAM_ADDR-1:0] raddr,
  output logic                rEnable,
  output logic                readFlag,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic [PIX_W-1:0]    peak_pixel,
  output logic [NB-1:0]       peak_bin,
  output logic [CNT_W-1:0]    peak_count,
  output logic                busy,
  output logic                findPeakFinish
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [RAM_ADDR-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0] max_q, max_d, max_n, peak_count_q, peak_count_d;
  logic [NB-1:0] mbin_q, mbin_d, mbin_n, peak_bin_q, peak_bin_d, bin, dbin;
  logic [PIX_W-1:0] pix, peak_pixel_q, peak_pixel_d;
  logic read_flag_q, read_flag_d, ren_q, ren_d, peak_valid_q, peak_valid_d;
  logic busy_q, busy_d, fin_q, fin_d, cmp, upd;
  // the address register doubles as the pixel/bin scan counter
  assign bin = raddr_q[NB-1:0];
  assign pix = raddr_q[RAM_ADDR-1:NB];
  assign raddr = raddr_q;
  assign rEnable = ren_q;
  assign readFlag = read_flag_q;
  assign peak_valid = peak_valid_q;
  assign peak_pixel = peak_pixel_q;
  assign peak_bin = peak_bin_q;
  assign peak_count = peak_count_q;
  assign busy = busy_q;
  assign findPeakFinish = fin_q;
  // read data lags the address by one cycle, so compare the bin issued in the previous cycle
  always_comb begin
    cmp = (state_q == READ && bin != '0) || state_q == DRAIN;
    dbin = state_q == DRAIN ? bin : bin - 1'b1;
    upd = cmp && counts > max_q;
    max_n = upd ? counts : max_q;
    mbin_n = upd ? dbin : mbin_q;
    state_d = state_q;
    raddr_d = raddr_q;
    max_d = max_n;
    mbin_d = mbin_n;
    peak_pixel_d = peak_pixel_q;
    peak_bin_d = peak_bin_q;
    peak_count_d = peak_count_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        raddr_d = '0;
        max_d = '0;
        mbin_d = '0;
      end
      READ: if (bin == NB'(BIN_NUM - 1)) state_d = DRAIN;
            else raddr_d = raddr_q + 1'b1;
      DRAIN: begin
        state_d = EMIT;
        peak_pixel_d = pix;
        peak_bin_d = mbin_n;
        peak_count_d = max_n;
      end
      EMIT: if (peak_ready) begin
        if (pix == PIX_W'(PIXEL_NUM - 1)) state_d = DONE;
        else begin
          state_d = READ;
          raddr_d = raddr_q + 1'b1;
          max_d = '0;
          mbin_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    read_flag_d = state_d == READ;
    ren_d = state_d != READ;
    peak_valid_d = state_d == EMIT;
    busy_d = state_d != IDLE;
    fin_d = state_d == DONE;
  end
  // state and registered outputs; reset aborts any scan in progress
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state_q <= IDLE;
      raddr_q <= '0;
      max_q <= '0;
      mbin_q <= '0;
      peak_pixel_q <= '0;
      peak_bin_q <= '0;
      peak_count_q <= '0;
      read_flag_q <= 1'b0;
      ren_q <= 1'b1;
      peak_valid_q <= 1'b0;
      busy_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      max_q <= max_d;
      mbin_q <= mbin_d;
      peak_pixel_q <= peak_pixel_d;
      peak_bin_q <= peak_bin_d;
      peak_count_q <= peak_count_d;
      read_flag_q <= read_flag_d;
      ren_q <= ren_d;
      peak_valid_q <= peak_valid_d;
      busy_q <= busy_d;
      fin_q <= fin_d;
    end
endmodule

// File: tb/tb_sifh_peak_reader.sv
// tb_sifh_peak_reader: directed checks of the histogram peak reader against a small SRAM model
module tb_sifh_peak_reader;
  logic clk = 0, res = 1, start = 0, peak_ready = 1, clr = 0, hold = 0;
  logic [9:0] counts;
  logic [5:0] raddr;
  logic rEnable, readFlag, peak_valid, busy, findPeakFinish;
  logic [1:0] peak_pixel;
  logic [3:0] peak_bin;
  logic [9:0] peak_count;
  logic [15:0] held, hp;
  logic [9:0] mem [64];
  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0;
  int nres, nfin, fin_cyc, rexp, raddr_bad, ren_bad, stab_bad;
  int r_pix [8], r_bin [8], r_cnt [8], e_bin [4], e_cnt [4];

  always #5 clk = ~clk;

  sifh_peak_reader dut (
    .clk(clk), .res(res), .start(start), .counts(counts), .raddr(raddr),
    .rEnable(rEnable), .readFlag(readFlag), .peak_valid(peak_valid),
    .peak_ready(peak_ready), .peak_pixel(peak_pixel), .peak_bin(peak_bin),
    .peak_count(peak_count), .busy(busy), .findPeakFinish(findPeakFinish)
  );

  // synchronous SRAM port b: data one cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (readFlag && !rEnable) counts <= mem[raddr];
  end

  // observe the interface mid-cycle
  always @(negedge clk) begin
    if (clr) begin
      nres = 0; nfin = 0; fin_cyc = 0; rexp = 0; raddr_bad = 0; ren_bad = 0; stab_bad = 0; hold = 0;
    end else begin
      if (rEnable != !readFlag) ren_bad++;
      if (readFlag) begin
        if (raddr != 6'(rexp)) raddr_bad++;
        rexp++;
      end
      if (findPeakFinish) begin
        nfin++;
        fin_cyc = cyc - t0 + 1;
      end
      if (peak_valid && peak_ready && nres < 8) begin
        r_pix[nres] = peak_pixel; r_bin[nres] = peak_bin; r_cnt[nres] = peak_count;
        nres++;
      end
      if (peak_valid && !peak_ready) begin
        if (hold && held != {peak_pixel, peak_bin, peak_count}) stab_bad++;
        hold = 1;
        held = {peak_pixel, peak_bin, peak_count};
      end else hold = 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_a();
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 16; b++) mem[p*16+b] = (b == 3 + p) ? 10'(10*p+5) : 10'd1;
  endtask

  task automatic frame_begin();
    clr = 1;
    @(negedge clk);
    #1 clr = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
  endtask

  task automatic wait_fin();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (findPeakFinish) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int efin);
    check({tag, "_n_results"}, nres, 4);
    check({tag, "_n_finish"}, nfin, 1);
    check({tag, "_finish_cycle"}, fin_cyc, efin);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_pix%0d", tag, i), r_pix[i], i);
      check($sformatf("%s_bin%0d", tag, i), r_bin[i], e_bin[i]);
      check($sformatf("%s_cnt%0d", tag, i), r_cnt[i], e_cnt[i]);
    end
    check({tag, "_raddr_seq_errs"}, raddr_bad, 0);
    check({tag, "_reads"}, rexp, 64);
    check({tag, "_renable_errs"}, ren_bad, 0);
    check({tag, "_stable_errs"}, stab_bad, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_renable"}, rEnable, 1);
    check({tag, "_readflag"}, readFlag, 0);
    check({tag, "_valid"}, peak_valid, 0);
    check({tag, "_pixel"}, peak_pixel, 0);
    check({tag, "_bin"}, peak_bin, 0);
    check({tag, "_count"}, peak_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, findPeakFinish, 0);
  endtask

  initial begin
    load_a();
    #2 res = 0;
    #10 check_reset("rst");
    next_cycle();
    res = 1;
    // basic frame with ready high
    frame_begin();
    pulse_start();
    wait_fin();
    e_bin = '{3, 4, 5, 6};
    e_cnt = '{5, 15, 25, 35};
    check_frame("basic", 73);
    // ties, last-bin capture, full-width count, all-zero pixel
    for (int i = 0; i < 64; i++) mem[i] = (i >= 16 && i < 32) ? 10'd500 : 10'd0;
    mem[2] = 7; mem[9] = 7; mem[31] = 1023; mem[56] = 2;
    frame_begin();
    pulse_start();
    wait_fin();
    e_bin = '{2, 15, 0, 8};
    e_cnt = '{7, 1023, 0, 2};
    check_frame("tie", 73);
    // backpressure on pixel 1 for five cycles
    load_a();
    frame_begin();
    pulse_start();
    for (int i = 0; i < 100 && !(readFlag && raddr == 31); i++) next_cycle();
    peak_ready = 0;
    for (int i = 0; i < 100 && !peak_valid; i++) next_cycle();
    hp = {peak_pixel, peak_bin, peak_count};
    check("bp_pixel", peak_pixel, 1);
    check("bp_count", peak_count, 15);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check($sformatf("bp_hold%0d", k), {peak_valid, peak_pixel, peak_bin, peak_count}, {1'b1, hp});
      check($sformatf("bp_raddr%0d", k), raddr, 31);
      check($sformatf("bp_readflag%0d", k), readFlag, 0);
    end
    peak_ready = 1;
    next_cycle();
    check("bp_resume_raddr", raddr, 32);
    check("bp_resume_readflag", readFlag, 1);
    wait_fin();
    e_bin = '{3, 4, 5, 6};
    e_cnt = '{5, 15, 25, 35};
    check_frame("bp", 78);
    // a start pulse mid-scan is ignored
    frame_begin();
    pulse_start();
    repeat (8) next_cycle();
    start = 1;
    next_cycle();
    start = 0;
    wait_fin();
    check_frame("busy_start", 73);
    // reset during pixel 2 aborts the scan
    frame_begin();
    pulse_start();
    for (int i = 0; i < 100 && !(readFlag && raddr == 34); i++) next_cycle();
    #2 res = 0;
    #1 check_reset("midrst");
    repeat (3) next_cycle();
    res = 1;
    repeat (3) @(negedge clk);
    check("midrst_results", nres, 2);
    check("midrst_finish", nfin, 0);
    frame_begin();
    pulse_start();
    wait_fin();
    check_frame("after_rst", 73);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sifh_peak_reader.md
Name: sifh_peak_reader

Overview:
- Reader side of the histogram SRAM: after a histogram build completes, it scans every bin of every pixel through SRAM port b.
- Per pixel, it finds the maximum bin count and its bin index, then hands each result downstream with a valid/ready handshake.
- It sits between the histogram SRAM (port b) and the filter/threshold stage.
- It produces the findPeakFinish pulse consumed by the SiFH top-level FSM in states M1/M4.

Parameters:
- BIN_NUM, 16, bins per histogram (power of two).
- PIXEL_NUM, 4, pixels per RAM (power of two).
- NB, 4, bin index width, log2(BIN_NUM).
- PIX_W, 2, pixel index width, log2(PIXEL_NUM).
- RAM_ADDR, 6, SRAM address width, NB+PIX_W.
- CNT_W, 10, bin count width (peakMax).

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to scan all pixels; ignored unless in IDLE.
- counts  in  CNT_W  SRAM port-b read data, valid 1 cycle after address issue.
- raddr  out  RAM_ADDR  SRAM port-b address (addrb).
- rEnable  out  1  SRAM port-b read enable, active low (0 = read).
- readFlag  out  1  SRAM port-b memory enable (meb), active high.
- peak_valid  out  1  result valid; held until accepted.
- peak_ready  in  1  downstream accepts the result when high together with peak_valid.
- peak_pixel  out  PIX_W  pixel index of the result.
- peak_bin  out  NB  bin index of the maximum.
- peak_count  out  CNT_W  maximum count.
- busy  out  1  high in every state except IDLE.
- findPeakFinish  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values (res low, asynchronous):
  - state=IDLE.
  - raddr=0, rEnable=1, readFlag=0.
  - peak_valid=0, peak_pixel=0, peak_bin=0, peak_count=0.
  - busy=0, findPeakFinish=0.
  - Internal pixel/bin counters and the running max are cleared.
- Reset mid-scan aborts immediately. No partial result is emitted and no findPeakFinish is produced.
- States: IDLE, READ, DRAIN, EMIT, DONE. All outputs are registered.
- IDLE:
  - rEnable=1, readFlag=0.
  - start=1 → READ; pixel=0, bin=0, max=0, maxbin=0.
- READ:
  - Each cycle: raddr={pixel,bin}, i.e. pixel*BIN_NUM+bin; readFlag=1, rEnable=0; bin increments.
  - From the second READ cycle on, the previous address's counts is compared against max.
  - After bin=BIN_NUM-1 is issued → DRAIN.
- DRAIN:
  - readFlag=0, rEnable=1; the last bin's counts is compared.
  - Next state EMIT; the result registers load {pixel, maxbin, max} at this edge.
- Compare rule:
  - Update only when counts > max (strict), so on ties the lowest bin index wins.
  - An all-zero histogram yields bin 0, count 0.
- EMIT:
  - peak_valid=1; peak_* must stay stable until peak_valid && peak_ready.
  - On handshake: peak_valid=0. If pixel==PIXEL_NUM-1 → DONE; else pixel+1, bin=0, max=0 → READ.
  - No SRAM access occurs while waiting.
- DONE: findPeakFinish=1 for exactly one cycle → IDLE.
- Timing with peak_ready tied high: BIN_NUM+2 cycles per pixel.
- Frame timing: if start is sampled at edge 0, findPeakFinish is high in cycle PIXEL_NUM*(BIN_NUM+2)+1, which is 73 for the defaults.
- No address wrap beyond PIXEL_NUM*BIN_NUM-1; the last raddr issued is 63.
- Read-only: the block never drives port a.
- start asserted while busy has no effect; a start coinciding with the findPeakFinish cycle is also ignored.

Test Plan:
- Peak per pixel: preload pixel p with count = 10*p+5 at bin = 3+p and all other bins 1; pulse start, ready high → four results (0,3,5), (1,4,15), (2,5,25), (3,6,35); findPeakFinish in cycle 73; raddr sequence 0..63 with rEnable=0 only in READ.
- Tie and edge bins: pixel 0 has count 7 at bins 2 and 9 → bin 2 count 7. Pixel 1 has its max 1023 at bin 15, checking DRAIN capture and full width → bin 15 count 1023. Pixel 2 all zero → bin 0 count 0.
- Backpressure: hold peak_ready low for 5 cycles at pixel 1 → peak_* stable, raddr frozen, readFlag=0. Release → scan resumes at raddr 32; findPeakFinish shifts by 5 cycles.
- Start while busy: a second start pulse at cycle 10 → no restart, exactly four results, one findPeakFinish.
- Reset mid-scan: drop res during pixel 2 READ → all outputs at reset values that cycle, no findPeakFinish. A new start after release → full correct scan from raddr 0.
